// File: rtl/host_mmio_pkg.sv
// host_mmio_pkg: register offsets, TOHOST pass code and console status layout.
package host_mmio_pkg;
  localparam logic [1:0] OFF_TOHOST = 2'd0;
  localparam logic [1:0] OFF_CONSOLE = 2'd1;
  localparam logic [1:0] OFF_CYCLE = 2'd2;
  localparam logic [31:0] TOHOST_PASS = 32'd1;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF = 2;
  localparam int ST_COUNT = 8;
  function automatic logic [31:0] status_word(input logic [7:0] count, input logic ovf, empty, full);
    return (32'(count) << ST_COUNT) | (32'(ovf) << ST_OVF) | (32'(empty) << ST_EMPTY) | (32'(full) << ST_FULL);
  endfunction
endpackage

// File: rtl/host_mmio_byte_fifo.sv
// byte_fifo: registered byte FIFO; push while full is accepted only alongside a pop.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? 8'h00 : mem[rd];
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= push_data;
endmodule

// File: rtl/host_mmio.sv
// host_mmio: 16-byte MMIO window with TOHOST exit latch, console FIFO stream and cycle counter.
module host_mmio
  import host_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  wmask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic        pass
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0] tohost, cycle;
  logic [CW-1:0] count;
  logic [1:0] off;
  logic ovf, empty, full, push, pop, tohost_we, unused_addr;
  assign sel = addr[31:4] == BASE_ADDR[31:4];
  assign off = addr[3:2];
  assign unused_addr = ^addr[1:0];
  assign push = we && sel && off == OFF_CONSOLE && wmask[0];
  assign tohost_we = we && sel && off == OFF_TOHOST && wmask == 4'hF && wdata != '0 && !done;
  assign tx_valid = !empty;
  assign pop = tx_valid && tx_ready;
  assign done = tohost != '0;
  assign pass = tohost == TOHOST_PASS;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(wdata[7:0]),
    .pop(pop),
    .head(tx_data),
    .empty(empty),
    .full(full),
    .count(count)
  );
  // a full FIFO only drops the byte when nothing leaves in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      tohost <= '0;
      cycle <= '0;
      ovf <= 1'b0;
    end else begin
      if (tohost_we) tohost <= wdata;
      if (push && full && !pop) ovf <= 1'b1;
      cycle <= cycle + 32'd1;
    end
  end
  always_comb
    rdata = !sel ? '0 :
            off == OFF_TOHOST ? tohost :
            off == OFF_CONSOLE ? status_word(8'(count), ovf, empty, full) :
            off == OFF_CYCLE ? cycle : '0;
endmodule

// File: doc/host_mmio.md
# host_mmio

Memory-mapped host responder on the rv32i_cpu data port, alongside dmem at the top level. It decodes a 16-byte window at BASE_ADDR and provides three registers. TOHOST latches the test exit code and raises done/pass. CONSOLE feeds a byte FIFO that drains onto a valid/ready stream toward the bench. CYCLE is a free-running cycle counter. The top level routes mem_rdata from this block when `sel` is high, otherwise from dmem.

## Interface
- BASE_ADDR, 32'h00001000, window base; must be 16-byte aligned.
- FIFO_DEPTH, 16, console FIFO entries; power of two, ≥2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write strobe from the CPU data port.
- wmask  in  4  byte-lane enables.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr; 0 when not selected.
- sel  out  1  combinational; high when addr[31:4] == BASE_ADDR[31:4].
- tx_valid  out  1  console byte available.
- tx_data  out  8  console byte at the FIFO head.
- tx_ready  in  1  consumer accepts the byte.
- done  out  1  TOHOST has latched a nonzero value.
- pass  out  1  done && tohost == 1.

## Operation
- Register offset is addr[3:2]. addr[1:0] are ignored.
- 0x0 TOHOST:
  - A write with we && sel && wmask == 4'hF && wdata != 0 while !done latches wdata and sets done.
  - All later writes are ignored until reset. Zero writes and partial-mask writes are ignored.
  - Read returns the latched value (0 before done).
- 0x4 CONSOLE:
  - A write with we && sel && wmask[0] pushes wdata[7:0].
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and sticky `ovf` is set.
  - Read returns {16'b0, count[7:0], 5'b0, ovf, empty, full}.
  - A write with wmask[0] == 0 does nothing.
- 0x8 CYCLE:
  - Increments every cycle after reset and wraps at 2^32.
  - Writes are ignored. Read returns the current value.
- 0xC: reserved; reads 0, writes ignored.
- FIFO:
  - Pop occurs when tx_valid && tx_ready.
  - Simultaneous push and pop when full is accepted: count is unchanged and `ovf` is not set.
  - Simultaneous push and pop when empty: the pop has no effect (tx_valid is low) and the push is stored.
  - count ranges 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- There is no wait state and no handshake on the CPU side. Every access completes in its cycle.

## Timing
- Register state updates on posedge clk. rdata and sel are purely combinational from addr and the current state.
- Reset values:
  - tohost = 0, done = 0, pass = 0.
  - cycle = 0.
  - FIFO empty, count = 0, ovf = 0.
  - tx_valid = 0, tx_data = 0.
- Reset asserted mid-stream flushes the FIFO and clears everything above on the next edge, regardless of tx_ready.
- Push-to-tx_valid latency is 1 cycle (registered, no fall-through).
- tx_data is stable while tx_valid && !tx_ready.
- A TOHOST write in cycle N gives done/pass high after edge N. It is visible to a bench sampling mem_word(BASE_ADDR) through rdata in the same edge window.
- CYCLE reads 0 in the first cycle after reset deassertion. A read in cycle k returns k.

## Structure
- Package `host_mmio_pkg`:
  - Offset constants OFF_TOHOST = 2'd0, OFF_CONSOLE = 2'd1, OFF_CYCLE = 2'd2.
  - TOHOST_PASS = 32'd1.
  - Console status bit positions.
- Sub-module `byte_fifo`:
  - Parameter DEPTH; 8-bit data.
  - Ports push, push_data, pop, head, empty, full, count.
- host_mmio holds the decode logic, the TOHOST and CYCLE registers, ovf, and the read mux.

## Test plan
- Reset, then write 32'h1 to 0x1000 with wmask = F → done = 1, pass = 1 next cycle, rdata@0x1000 = 1. A second write of 32'h5 is ignored.
- Write 32'h7 to 0x1000 → done = 1, pass = 0, rdata = 7. Beforehand, a write of 0 and a write with wmask = 4'h3 leave done = 0.
- tx_ready = 0, push 'H','i' to 0x1004 → tx_valid one cycle after the first push, tx_data = 8'h48, status count = 2. Raise tx_ready → 8'h48 then 8'h69 are popped, then empty = 1.
- tx_ready = 0, push FIFO_DEPTH+1 bytes → full = 1, ovf = 1, count = 16, and the 17th byte is absent when draining.
- With the FIFO full, push while tx_ready = 1 → count stays 16, ovf stays 0, ordering is preserved.
- Read 0x1008 at k cycles after reset → k. Assert reset with 3 bytes queued → tx_valid = 0, count = 0, cycle = 0 next cycle. Reads of 0x100C and of addr 0x2000 return 0, and sel = 0 for 0x2000.
